channel_config_regs: RTL

- Parametrised successor of the channel-mux register block.
- CPU-facing register file with double-buffered channel enable/select registers.
- CPU writes go to shadow registers. The active outputs update only on a commit, either immediately or armed to the next `i_sync` pulse (e.g. PPS), so all channels switch in the same cycle.
- Adds sticky status flags and an explicit read handshake. Sits between the bus decoder and the channel mux.

---
 rtl/channel_config_regs_pkg.sv | 25 ++
 rtl/channel_config_regs_commit.sv | 55 +++++
 rtl/channel_config_regs.sv | 116 +++++++++++
 3 files changed

// File: rtl/channel_config_regs_pkg.sv
// Shared definitions for the channel configuration register block.
// Covers register offsets, CTRL/STATUS bit positions and the commit FSM encoding.
package channel_config_regs_pkg;

    localparam logic [2:0] ENA_SHADOW_OFS = 3'd0;
    localparam logic [2:0] SEL_SHADOW_OFS = 3'd1;
    localparam logic [2:0] CTRL_OFS       = 3'd2;
    localparam logic [2:0] STATUS_OFS     = 3'd3;
    localparam logic [2:0] ENA_ACTIVE_OFS = 3'd4;
    localparam logic [2:0] SEL_ACTIVE_OFS = 3'd5;

    localparam int CTRL_COMMIT_NOW_BIT     = 0;
    localparam int CTRL_COMMIT_ON_SYNC_BIT = 1;
    localparam int CTRL_CANCEL_BIT         = 2;

    localparam int STATUS_PENDING_BIT = 0;
    localparam int STATUS_DONE_BIT    = 1;
    localparam int STATUS_WR_ERR_BIT  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } commit_state_t;

endpackage

// File: rtl/channel_config_regs_commit.sv
// Commit sequencer: decides when shadow registers are copied to the active outputs.
// do_commit is combinational; the top loads the actives on the same clock edge.
module commit_fsm
    import channel_config_regs_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          commit_now,
    input  logic          commit_on_sync,
    input  logic          cancel,
    input  logic          i_sync,
    output logic          do_commit,
    output logic          pending,
    output commit_state_t state
);

    commit_state_t next_state;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A sync pulse arriving together with the arming write is not consumed.
    always_comb begin
        next_state = state;
        do_commit  = 1'b0;
        case (state)
            IDLE: begin
                if (cancel) begin
                    next_state = IDLE;
                end else if (commit_now) begin
                    do_commit = 1'b1;
                end else if (commit_on_sync) begin
                    next_state = ARMED;
                end
            end
            ARMED: begin
                if (cancel) begin
                    next_state = IDLE;
                end else if (commit_now || i_sync) begin
                    do_commit  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign pending = (state == ARMED);

endmodule

// File: rtl/channel_config_regs.sv
// CPU register file with double-buffered channel enable/select registers.
// Shadows are written by the CPU; actives change only on a commit.
module channel_config_regs
    import channel_config_regs_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    N_CH       = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_wr,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_rd_valid,
    input  logic                  i_sync,
    output logic [N_CH-1:0]       o_ch_ena,
    output logic [N_CH-1:0]       o_ch_sel,
    output logic                  o_commit_pending
);

    if (N_CH < 1 || N_CH > DATA_WIDTH || DATA_WIDTH < 3) begin : g_bad_params
        $error("channel_config_regs: N_CH must be 1..DATA_WIDTH and DATA_WIDTH >= 3");
    end

    logic [ADDR_WIDTH-1:0] offset;
    logic [2:0]            ofs;
    logic                  hit, wr_en, rd_en;
    logic                  ctrl_wr, status_wr, active_wr;
    logic                  do_commit, pending;
    commit_state_t         fsm_state;
    logic [N_CH-1:0]       ena_shadow, sel_shadow, ena_active, sel_active;
    logic                  commit_done, wr_err;
    logic [DATA_WIDTH-1:0] rd_data, data_q;
    logic                  rd_valid_q;
    logic                  unused_bits;

    assign offset    = i_addr - BASE_ADDR;
    assign hit       = (i_addr >= BASE_ADDR) && (offset <= ADDR_WIDTH'(SEL_ACTIVE_OFS));
    assign ofs       = offset[2:0];
    assign wr_en     = i_wr && hit;
    assign ctrl_wr   = wr_en && (ofs == CTRL_OFS);
    assign status_wr = wr_en && (ofs == STATUS_OFS);
    assign active_wr = wr_en && (ofs == ENA_ACTIVE_OFS || ofs == SEL_ACTIVE_OFS);

    // Read handshake: i_rd sampled with i_wr low yields o_data plus a
    // one-cycle o_rd_valid pulse on the next cycle; a concurrent write wins.
    assign rd_en = i_rd && !i_wr;

    commit_fsm u_commit_fsm (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .commit_now     (ctrl_wr && i_data[CTRL_COMMIT_NOW_BIT]),
        .commit_on_sync (ctrl_wr && i_data[CTRL_COMMIT_ON_SYNC_BIT]),
        .cancel         (ctrl_wr && i_data[CTRL_CANCEL_BIT]),
        .i_sync         (i_sync),
        .do_commit      (do_commit),
        .pending        (pending),
        .state          (fsm_state)
    );

    always_comb begin
        rd_data = '0;
        if (hit) begin
            case (ofs)
                ENA_SHADOW_OFS: rd_data[N_CH-1:0] = ena_shadow;
                SEL_SHADOW_OFS: rd_data[N_CH-1:0] = sel_shadow;
                STATUS_OFS: begin
                    rd_data[STATUS_PENDING_BIT] = pending;
                    rd_data[STATUS_DONE_BIT]    = commit_done;
                    rd_data[STATUS_WR_ERR_BIT]  = wr_err;
                end
                ENA_ACTIVE_OFS: rd_data[N_CH-1:0] = ena_active;
                SEL_ACTIVE_OFS: rd_data[N_CH-1:0] = sel_active;
                default: rd_data = '0;
            endcase
        end
    end

    // Commits copy the pre-write shadow; a same-cycle shadow write lands after.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ena_shadow  <= '0;
            sel_shadow  <= '0;
            ena_active  <= '0;
            sel_active  <= '0;
            commit_done <= 1'b0;
            wr_err      <= 1'b0;
            data_q      <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            if (do_commit) begin
                ena_active <= ena_shadow;
                sel_active <= sel_shadow;
            end
            if (wr_en && ofs == ENA_SHADOW_OFS) ena_shadow <= i_data[N_CH-1:0];
            if (wr_en && ofs == SEL_SHADOW_OFS) sel_shadow <= i_data[N_CH-1:0];
            commit_done <= do_commit || (commit_done && !(status_wr && i_data[STATUS_DONE_BIT]));
            wr_err      <= active_wr || (wr_err && !(status_wr && i_data[STATUS_WR_ERR_BIT]));
            rd_valid_q  <= rd_en;
            if (rd_en) data_q <= rd_data;
        end
    end

    assign o_data           = data_q;
    assign o_rd_valid       = rd_valid_q;
    assign o_ch_ena         = ena_active;
    assign o_ch_sel         = sel_active;
    assign o_commit_pending = pending;

    assign unused_bits = ^{i_data, fsm_state};

endmodule
